// File: rtl/multi_input_accumulator.sv
// Streaming frame accumulator: a registered adder tree reduces each beat of NUM_INPUT lanes,
// and beat sums are accumulated per frame, with one total (plus beat count/overflow) per frame.
module multi_input_accumulator #(
  parameter int NUM_INPUT   = 45,
  parameter int WIDTH_IN    = 16,
  parameter int MAX_BEATS   = 256,
  parameter int TREE_STAGES = 3,
  parameter int WIDTH_TREE  = WIDTH_IN + $clog2(NUM_INPUT),
  parameter int WIDTH_OUT   = WIDTH_TREE + $clog2(MAX_BEATS),
  parameter int WIDTH_CNT   = $clog2(MAX_BEATS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic                 in_signed,
  input  logic [WIDTH_IN-1:0]  din [NUM_INPUT],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH_OUT-1:0] dout,
  output logic [WIDTH_CNT-1:0] out_beats,
  output logic                 out_overflow
);

  // Smallest fan-in per level so that TREE_STAGES levels reduce NUM_INPUT lanes to one.
  function automatic int calc_group();
    int found;
    int p;
    found = NUM_INPUT;
    for (int g = NUM_INPUT; g >= 2; g--) begin
      p = 1;
      for (int i = 0; i < TREE_STAGES; i++) begin
        if (p < NUM_INPUT) p = p * g;
      end
      if (p >= NUM_INPUT) found = g;
    end
    return found;
  endfunction

  localparam int GROUP = calc_group();

  function automatic int lvl_cnt(input int s);
    int c;
    c = NUM_INPUT;
    for (int i = 0; i < s; i++) c = (c + GROUP - 1) / GROUP;
    return c;
  endfunction

  function automatic logic signed [WIDTH_TREE-1:0] ext_lane(input logic [WIDTH_IN-1:0] v,
                                                            input logic sgn);
    return sgn ? WIDTH_TREE'($signed(v)) : WIDTH_TREE'(v);
  endfunction

  function automatic logic signed [WIDTH_OUT-1:0] ext_sum(input logic signed [WIDTH_TREE-1:0] s,
                                                          input logic sgn);
    return sgn ? WIDTH_OUT'(s) : WIDTH_OUT'($unsigned(s));
  endfunction

  typedef enum logic {ST_FIRST, ST_MID} state_t;

  state_t state;
  logic   mode_q;
  logic   stall, advance, accept;
  logic   beat_first, beat_mode;

  assign stall      = out_valid && !out_ready;
  assign advance    = !stall;
  assign in_ready   = !rst && !stall;
  assign accept     = in_valid && in_ready;
  assign beat_first = (state == ST_FIRST);
  assign beat_mode  = beat_first ? in_signed : mode_q;

  logic signed [WIDTH_TREE-1:0] lane_ext [NUM_INPUT];
  logic signed [WIDTH_TREE-1:0] tree_nxt [TREE_STAGES][NUM_INPUT];
  logic signed [WIDTH_TREE-1:0] sum_p    [TREE_STAGES][NUM_INPUT];
  logic [TREE_STAGES-1:0]       vld_p, first_p, last_p, mode_p;

  always_comb begin
    for (int l = 0; l < NUM_INPUT; l++) lane_ext[l] = ext_lane(din[l], beat_mode);
  end

  // Level s sums groups of GROUP entries of level s-1; short groups are zero-padded.
  always_comb begin
    for (int s = 0; s < TREE_STAGES; s++) begin
      for (int j = 0; j < NUM_INPUT; j++) begin
        tree_nxt[s][j] = '0;
        for (int k = 0; k < GROUP; k++) begin
          if (j * GROUP + k < lvl_cnt(s)) begin
            if (s == 0) tree_nxt[s][j] = tree_nxt[s][j] + lane_ext[j * GROUP + k];
            else        tree_nxt[s][j] = tree_nxt[s][j] + sum_p[s-1][j * GROUP + k];
          end
        end
      end
    end
  end

  // Tree stages p0..p(TREE_STAGES-1): data and side-band move together.
  always_ff @(posedge clk) begin
    if (advance) begin
      for (int s = 0; s < TREE_STAGES; s++) begin
        for (int j = 0; j < NUM_INPUT; j++) sum_p[s][j] <= tree_nxt[s][j];
        if (s == 0) begin
          first_p[0] <= beat_first;
          last_p[0]  <= in_last;
          mode_p[0]  <= beat_mode;
        end else begin
          first_p[s] <= first_p[s-1];
          last_p[s]  <= last_p[s-1];
          mode_p[s]  <= mode_p[s-1];
        end
      end
    end
  end

  logic signed [WIDTH_OUT-1:0] exit_sum, acc, acc_nxt;
  logic [WIDTH_CNT-1:0]        beat_cnt, cnt_nxt;
  logic                        ovf, ovf_nxt, at_max, exit_first, done_p;

  always_comb begin
    exit_first = first_p[TREE_STAGES-1];
    exit_sum   = ext_sum(sum_p[TREE_STAGES-1][0], mode_p[TREE_STAGES-1]);
    at_max     = (beat_cnt == WIDTH_CNT'(MAX_BEATS));
    acc_nxt    = exit_first ? exit_sum : acc + exit_sum;
    cnt_nxt    = exit_first ? WIDTH_CNT'(1) : (at_max ? beat_cnt : beat_cnt + WIDTH_CNT'(1));
    ovf_nxt    = exit_first ? 1'b0 : (ovf || at_max);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_FIRST;
      mode_q       <= 1'b0;
      vld_p        <= '0;
      acc          <= '0;
      beat_cnt     <= '0;
      ovf          <= 1'b0;
      done_p       <= 1'b0;
      out_valid    <= 1'b0;
      dout         <= '0;
      out_beats    <= '0;
      out_overflow <= 1'b0;
    end else if (advance) begin
      if (accept) begin
        if (beat_first) mode_q <= in_signed;
        state <= in_last ? ST_FIRST : ST_MID;
      end
      for (int s = 0; s < TREE_STAGES; s++) begin
        if (s == 0) vld_p[0] <= accept;
        else        vld_p[s] <= vld_p[s-1];
      end
      // Accumulate stage: consumes the tree exit.
      if (vld_p[TREE_STAGES-1]) begin
        acc      <= acc_nxt;
        beat_cnt <= cnt_nxt;
        ovf      <= ovf_nxt;
      end
      done_p <= vld_p[TREE_STAGES-1] && last_p[TREE_STAGES-1];
      // Output stage: a completed frame reloads even while the previous result is being popped.
      if (done_p) begin
        out_valid    <= 1'b1;
        dout         <= acc;
        out_beats    <= beat_cnt;
        out_overflow <= ovf;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multi_input_accumulator.sv
// Bench for multi_input_accumulator: directed frames with known totals plus randomized
// frames/backpressure checked against a plain-arithmetic frame model.
module tb_multi_input_accumulator;

  localparam int NI = 45;
  localparam int WO = 30;
  localparam int WC = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_last = 1'b0;
  logic          in_signed = 1'b0;
  logic [15:0]   din [NI];
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [WO-1:0] dout;
  logic [WC-1:0] out_beats;
  logic          out_overflow;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int drv_timeouts = 0;

  logic [WO-1:0] exp_dout  [$];
  logic [WC-1:0] exp_beats [$];
  logic          exp_ovf   [$];

  multi_input_accumulator dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_signed(in_signed), .din(din), .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .out_beats(out_beats), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  // Must be entered just after a rising edge. Later beats drive the opposite in_signed,
  // which the DUT must ignore. The model total uses plain integer lane values.
  task automatic drive_frame(input int nbeats, input bit rnd, input logic [15:0] val,
                             input bit sgn, input bit close, input int gap_pct);
    longint total;
    longint total_v;
    int     wc;
    total = 0;
    for (int b = 0; b < nbeats; b++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        sync();
      end
      in_valid  = 1'b1;
      in_last   = close && (b == nbeats - 1);
      in_signed = (b == 0) ? sgn : ~sgn;
      for (int l = 0; l < NI; l++) begin
        din[l] = rnd ? 16'($urandom) : val;
        total += sgn ? longint'($signed(din[l])) : longint'(din[l]);
      end
      wc = 0;
      @(negedge clk);
      while (!in_ready && wc < 300) begin
        wc++;
        @(negedge clk);
      end
      if (!in_ready) drv_timeouts++;
      accept_cyc = cyc + 1;
      sync();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (close) begin
      total_v = total;
      exp_dout.push_back(total_v[WO-1:0]);
      exp_beats.push_back(nbeats > 256 ? 9'd256 : 9'(nbeats));
      exp_ovf.push_back(nbeats > 256);
    end
  endtask

  task automatic test_reset();
    for (int l = 0; l < NI; l++) din[l] = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %0b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++; if (dout !== '0 || out_beats !== '0 || out_overflow !== 1'b0) begin
      failures++; $display("FAIL reset_outputs: got dout=%0d beats=%0d ovf=%0b expected 0/0/0", dout, out_beats, out_overflow);
    end
    sync();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset: got %0b expected 1", in_ready); end
    sync();
  endtask

  task automatic test_single_unsigned();
    bit got;
    int rise;
    out_ready = 1'b1;
    drive_frame(1, 0, 16'hFFFF, 0, 1, 0);
    got = 0; rise = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (out_valid) begin got = 1; rise = cyc; end
    end
    checks++; if (!got) begin failures++; $display("FAIL single_u_timeout: got no out_valid expected result"); end
    checks++; if (rise - accept_cyc !== 4) begin failures++; $display("FAIL single_u_latency: got %0d expected 4", rise - accept_cyc); end
    checks++; if (dout !== 30'd2949075) begin failures++; $display("FAIL single_u_dout: got %0d expected 2949075", dout); end
    checks++; if (out_beats !== 9'd1 || out_overflow !== 1'b0) begin
      failures++; $display("FAIL single_u_side: got beats=%0d ovf=%0b expected 1/0", out_beats, out_overflow);
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_u_pulse: got out_valid=%0b expected 0", out_valid); end
    sync();
  endtask

  task automatic test_signed_mode();
    bit got;
    drive_frame(1, 0, 16'hFFFF, 1, 1, 0);
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin @(negedge clk); got = out_valid; end
    checks++; if (!got || dout !== 30'h3FFFFFD3) begin
      failures++; $display("FAIL signed_single: got valid=%0b dout=%h expected 3fffffd3", got, dout);
    end
    sync();
    drive_frame(2, 0, 16'h8000, 1, 1, 0);
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin @(negedge clk); got = out_valid; end
    checks++; if (!got || dout !== 30'h3FD30000) begin
      failures++; $display("FAIL signed_held: got valid=%0b dout=%h expected 3fd30000", got, dout);
    end
    checks++; if (out_beats !== 9'd2) begin failures++; $display("FAIL signed_held_beats: got %0d expected 2", out_beats); end
    sync();
  endtask

  task automatic test_full_frames();
    bit got;
    drive_frame(256, 0, 16'hFFFF, 0, 1, 0);
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin @(negedge clk); got = out_valid; end
    checks++; if (!got || dout !== 30'd754963200 || out_beats !== 9'd256 || out_overflow !== 1'b0) begin
      failures++; $display("FAIL full_unsigned: got valid=%0b dout=%0d beats=%0d ovf=%0b expected 754963200/256/0", got, dout, out_beats, out_overflow);
    end
    sync();
    drive_frame(256, 0, 16'h8000, 1, 1, 0);
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin @(negedge clk); got = out_valid; end
    checks++; if (!got || dout !== 30'd696254464 || out_overflow !== 1'b0) begin
      failures++; $display("FAIL full_signed: got valid=%0b dout=%0d ovf=%0b expected 696254464/0", got, dout, out_overflow);
    end
    sync();
    drive_frame(257, 0, 16'd1, 0, 1, 0);
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin @(negedge clk); got = out_valid; end
    checks++; if (!got || dout !== 30'd11565) begin
      failures++; $display("FAIL overflow_dout: got valid=%0b dout=%0d expected 11565", got, dout);
    end
    checks++; if (out_beats !== 9'd256 || out_overflow !== 1'b1) begin
      failures++; $display("FAIL overflow_flags: got beats=%0d ovf=%0b expected 256/1", out_beats, out_overflow);
    end
    sync();
  endtask

  task automatic test_backpressure();
    bit got;
    int bad;
    out_ready = 1'b0;
    drive_frame(1, 0, 16'd1, 0, 1, 0);
    drive_frame(1, 0, 16'd2, 0, 1, 0);
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin @(negedge clk); got = out_valid; end
    checks++; if (!got) begin failures++; $display("FAIL bp_first_timeout: got no out_valid expected result"); end
    bad = 0;
    for (int t = 0; t < 10; t++) begin
      if (t > 0) @(negedge clk);
      if (out_valid !== 1'b1 || dout !== 30'd45 || in_ready !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin
      failures++; $display("FAIL bp_hold: got %0d bad cycles (dout=%0d in_ready=%0b) expected 0", bad, dout, in_ready);
    end
    sync();
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || dout !== 30'd45) begin
      failures++; $display("FAIL bp_pop_first: got valid=%0b dout=%0d expected 1/45", out_valid, dout);
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || dout !== 30'd90 || out_beats !== 9'd1) begin
      failures++; $display("FAIL bp_pop_second: got valid=%0b dout=%0d beats=%0d expected 1/90/1", out_valid, dout, out_beats);
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain: got out_valid=%0b expected 0", out_valid); end
    sync();
  endtask

  task automatic test_reset_midframe();
    bit got;
    int spurious;
    out_ready = 1'b1;
    drive_frame(3, 0, 16'd1, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_mid_ready: got %0b expected 0", in_ready); end
    sync();
    rst = 1'b0;
    spurious = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) spurious++;
    end
    checks++; if (spurious !== 0) begin failures++; $display("FAIL rst_mid_spurious: got %0d output cycles expected 0", spurious); end
    sync();
    drive_frame(1, 0, 16'd1, 0, 1, 0);
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin @(negedge clk); got = out_valid; end
    checks++; if (!got || dout !== 30'd45 || out_beats !== 9'd1 || out_overflow !== 1'b0) begin
      failures++; $display("FAIL rst_mid_next: got valid=%0b dout=%0d beats=%0d ovf=%0b expected 1/45/1/0", got, dout, out_beats, out_overflow);
    end
    sync();
  endtask

  task automatic test_random();
    localparam int NF = 40;
    int got;
    int budget;
    bit stalled_prev;
    logic [WO-1:0] held;
    exp_dout.delete(); exp_beats.delete(); exp_ovf.delete();
    drv_timeouts = 0;
    got = 0; budget = 0; stalled_prev = 0; held = '0;
    fork
      begin
        for (int f = 0; f < NF; f++)
          drive_frame((f == 7) ? 260 : int'($urandom_range(1, 6)), 1, 16'd0, 1'($urandom_range(1)), 1, 25);
      end
      begin
        while (got < NF && budget < 20000) begin
          sync();
          out_ready = ($urandom_range(3) != 0);
          @(negedge clk);
          budget++;
          if (stalled_prev) begin
            checks++; if (out_valid !== 1'b1 || dout !== held) begin
              failures++; $display("FAIL rand_hold: got valid=%0b dout=%0d expected 1/%0d", out_valid, dout, held);
            end
          end
          if (out_valid && out_ready) begin
            checks++;
            if (exp_dout.size() == 0) begin
              failures++; $display("FAIL rand_unexpected: got dout=%0d expected no result", dout);
            end else begin
              if (dout !== exp_dout[0] || out_beats !== exp_beats[0] || out_overflow !== exp_ovf[0]) begin
                failures++;
                $display("FAIL rand_frame%0d: got dout=%0d beats=%0d ovf=%0b expected %0d/%0d/%0b",
                         got, dout, out_beats, out_overflow, exp_dout[0], exp_beats[0], exp_ovf[0]);
              end
              void'(exp_dout.pop_front()); void'(exp_beats.pop_front()); void'(exp_ovf.pop_front());
            end
            got++;
          end
          stalled_prev = out_valid && !out_ready;
          held = dout;
        end
      end
    join
    checks++; if (got !== NF) begin failures++; $display("FAIL rand_count: got %0d results expected %0d", got, NF); end
    checks++; if (drv_timeouts !== 0) begin failures++; $display("FAIL rand_accept_timeout: got %0d expected 0", drv_timeouts); end
    out_ready = 1'b1;
    sync();
  endtask

  initial begin
    test_reset();
    test_single_unsigned();
    test_signed_mode();
    test_full_frames();
    test_backpressure();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
